// File: rtl/demux_stream_1n_if.sv
// Stream bundle for the 1-to-N packet demultiplexer.
// The producer side (in_*, sel) and the consumer side (out_*) travel together;
// slave is the demux view, master is the view of whoever drives it.
interface demux_stream_1n_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic [SELW-1:0]  sel;
  logic [N-1:0]     out_valid;
  logic [N-1:0]     out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport slave (
    input  in_valid, in_data, in_last, sel, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, in_last, sel, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/demux_stream_1n.sv
// demux_stream_1n: 1-to-N packet demultiplexer with a single registered
// output stage. The destination is taken from sel on the first beat of a
// packet and held until the last beat, so a packet never splits across
// channels. Each stored beat carries its own channel, so backpressure is
// local to the channel currently held in the output register.
//
// Build option DEMUX_DROP_EN: when defined, a packet whose first beat has
// sel >= N is swallowed (accepted and discarded) and drop_pulse marks its
// last beat. When undefined, an out-of-range sel is clamped to N-1.
module demux_stream_1n #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  demux_stream_1n_if.slave   bus,
  output logic               busy
`ifdef DEMUX_DROP_EN
  ,
  output logic               drop_pulse
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_t;

  localparam logic [SELW:0]   N_EXT   = (SELW + 1)'(N);
  localparam logic [SELW-1:0] LAST_CH = SELW'(N - 1);

  // Select bit idx of a per-channel vector without indexing past N.
  function automatic logic pick_bit(input logic [N-1:0] vec, input logic [SELW-1:0] idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N; i++) begin
      r = (idx == SELW'(i)) ? vec[i] : r;
    end
    return r;
  endfunction

  // One-hot channel mask for a destination index.
  function automatic logic [N-1:0] onehot(input logic [SELW-1:0] idx);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      r[i] = (idx == SELW'(i));
    end
    return r;
  endfunction

  state_t           state;
  logic [SELW-1:0]  cur_sel;
  logic [SELW-1:0]  out_sel_q;
  logic [N-1:0]     out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_last_q;

  logic             occupied;
  logic             sel_oob;
  logic [SELW-1:0]  sel_fix;
  logic [SELW-1:0]  dest;
  logic             ready_sel;
  logic             drop_beat;
  logic             in_ready_s;
  logic             accept;
  logic             load;
  logic             drain;

  // Handshake and routing decisions for the current cycle.
  always_comb begin
    occupied  = |out_valid_q;
    sel_oob   = ({1'b0, bus.sel} >= N_EXT);
    sel_fix   = sel_oob ? LAST_CH : bus.sel;
    dest      = (state == IDLE) ? sel_fix : cur_sel;
    ready_sel = pick_bit(bus.out_ready, out_sel_q);
`ifdef DEMUX_DROP_EN
    drop_beat = (state == DROP) || ((state == IDLE) && sel_oob);
`else
    drop_beat = 1'b0;
`endif
    // A dropped beat never touches the register, so it needs no room there.
    in_ready_s = drop_beat | ~occupied | ready_sel;
    accept     = bus.in_valid & in_ready_s;
    load       = accept & ~drop_beat;
    drain      = occupied & ready_sel;
  end

  // Output register: load (possibly in the same cycle as a drain) or empty on drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else if (load) begin
      out_valid_q <= onehot(dest);
      out_data_q  <= bus.in_data;
      out_last_q  <= bus.in_last;
      out_sel_q   <= dest;
    end else if (drain) begin
      out_valid_q <= '0;
    end else begin
      out_valid_q <= out_valid_q;
    end
  end

  // Packet FSM: latch the destination on the first beat, release it on the last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cur_sel <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (drop_beat) begin
              state <= bus.in_last ? IDLE : DROP;
            end else begin
              cur_sel <= sel_fix;
              state   <= bus.in_last ? IDLE : ROUTE;
            end
          end else begin
            state <= IDLE;
          end
        end
        ROUTE: begin
          if (accept && bus.in_last) begin
            state <= IDLE;
          end else begin
            state <= ROUTE;
          end
        end
        DROP: begin
          if (accept && bus.in_last) begin
            state <= IDLE;
          end else begin
            state <= DROP;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef DEMUX_DROP_EN
  logic drop_pulse_q;

  // One-cycle marker when the last beat of a swallowed packet is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_pulse_q <= 1'b0;
    end else begin
      drop_pulse_q <= accept & drop_beat & bus.in_last;
    end
  end

  assign drop_pulse = drop_pulse_q;
`endif

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign busy          = (state != IDLE) | occupied;

endmodule

// File: tb/tb_demux_stream_1n.sv
// Directed self-checking bench for demux_stream_1n.
// Instance a: N=4 (main behaviour). Instance b: N=3 (out-of-range sel).
module tb_demux_stream_1n;

  logic clk = 1'b0;
  logic rst;
  logic busy_a, busy_b;
`ifdef DEMUX_DROP_EN
  logic drop_a, drop_b;
`endif
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  demux_stream_1n_if #(.WIDTH(8), .N(4), .SELW(2)) ifa ();
  demux_stream_1n_if #(.WIDTH(8), .N(3), .SELW(2)) ifb ();

  demux_stream_1n #(.WIDTH(8), .N(4), .SELW(2)) dut_a (
    .clk  (clk),
    .rst  (rst),
    .bus  (ifa),
    .busy (busy_a)
`ifdef DEMUX_DROP_EN
    ,
    .drop_pulse (drop_a)
`endif
  );

  demux_stream_1n #(.WIDTH(8), .N(3), .SELW(2)) dut_b (
    .clk  (clk),
    .rst  (rst),
    .bus  (ifb),
    .busy (busy_b)
`ifdef DEMUX_DROP_EN
    ,
    .drop_pulse (drop_b)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_a(input logic v, input logic [1:0] s, input logic [7:0] d, input logic l);
    ifa.in_valid = v;
    ifa.sel      = s;
    ifa.in_data  = d;
    ifa.in_last  = l;
  endtask

  task automatic drive_b(input logic v, input logic [1:0] s, input logic [7:0] d, input logic l);
    ifb.in_valid = v;
    ifb.sel      = s;
    ifb.in_data  = d;
    ifb.in_last  = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive_a(1'b0, 2'd0, 8'h00, 1'b0);
    drive_b(1'b0, 2'd0, 8'h00, 1'b0);
    ifa.out_ready = 4'b0000;
    ifb.out_ready = 3'b111;
    tick();
    tick();

    // Reset state
    chk("rst_valid", 16'(ifa.out_valid), 16'h0);
    chk("rst_data",  16'(ifa.out_data),  16'h0);
    chk("rst_last",  16'(ifa.out_last),  16'h0);
    chk("rst_busy",  16'(busy_a),        16'h0);
    rst = 1'b0;
    #1;
    chk("rst_ready", 16'(ifa.in_ready),  16'h1);

    // Single-beat packet to ch2
    ifa.out_ready = 4'b1111;
    drive_a(1'b1, 2'd2, 8'hA5, 1'b1);
    tick();
    drive_a(1'b0, 2'd0, 8'h00, 1'b0);
    chk("t1_valid", 16'(ifa.out_valid), 16'h4);
    chk("t1_data",  16'(ifa.out_data),  16'hA5);
    chk("t1_last",  16'(ifa.out_last),  16'h1);
    chk("t1_busy",  16'(busy_a),        16'h1);
    tick();
    chk("t1_drain", 16'(ifa.out_valid), 16'h0);
    chk("t1_idle",  16'(busy_a),        16'h0);

    // 4-beat packet: sel=1 on the first beat, sel=3 afterwards is ignored
    for (int k = 0; k < 4; k++) begin
      drive_a(1'b1, (k == 0) ? 2'd1 : 2'd3, 8'(8'h10 + k), (k == 3));
      #1;
      chk("t2_ready", 16'(ifa.in_ready), 16'h1);
      tick();
      chk("t2_valid", 16'(ifa.out_valid), 16'h2);
      chk("t2_data",  16'(ifa.out_data),  16'(8'h10 + k));
      chk("t2_last",  16'(ifa.out_last),  16'((k == 3) ? 1 : 0));
    end
    drive_a(1'b0, 2'd0, 8'h00, 1'b0);
    tick();
    chk("t2_drain", 16'(ifa.out_valid), 16'h0);

    // ch0 stalled for 5 cycles while the other channels are ready
    ifa.out_ready = 4'b1110;
    drive_a(1'b1, 2'd0, 8'h10, 1'b0);
    tick();
    chk("t3_first", 16'(ifa.out_valid), 16'h1);
    drive_a(1'b1, 2'd0, 8'h11, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t3_stall_rdy", 16'(ifa.in_ready), 16'h0);
      tick();
      chk("t3_hold_data",  16'(ifa.out_data),  16'h10);
      chk("t3_hold_valid", 16'(ifa.out_valid), 16'h1);
    end
    ifa.out_ready = 4'b1111;
    #1;
    chk("t3_resume_rdy", 16'(ifa.in_ready), 16'h1);
    tick();
    drive_a(1'b0, 2'd0, 8'h00, 1'b0);
    chk("t3_second_valid", 16'(ifa.out_valid), 16'h1);
    chk("t3_second_data",  16'(ifa.out_data),  16'h11);
    chk("t3_second_last",  16'(ifa.out_last),  16'h1);
    tick();
    chk("t3_drain", 16'(ifa.out_valid), 16'h0);
    chk("t3_idle",  16'(busy_a),        16'h0);

    // Back-to-back: ch3 two beats, then ch0 one beat
    drive_a(1'b1, 2'd3, 8'h30, 1'b0);
    tick();
    chk("t4_b0", 16'(ifa.out_valid), 16'h8);
    drive_a(1'b1, 2'd1, 8'h31, 1'b1);
    tick();
    chk("t4_b1", 16'(ifa.out_valid), 16'h8);
    chk("t4_b1_last", 16'(ifa.out_last), 16'h1);
    drive_a(1'b1, 2'd0, 8'h40, 1'b1);
    tick();
    chk("t4_b2", 16'(ifa.out_valid), 16'h1);
    chk("t4_b2_data", 16'(ifa.out_data), 16'h40);
    drive_a(1'b0, 2'd0, 8'h00, 1'b0);
    tick();
    chk("t4_drain", 16'(ifa.out_valid), 16'h0);

    // Reset during beat 2 of a 4-beat packet to ch2
    drive_a(1'b1, 2'd2, 8'h50, 1'b0);
    tick();
    drive_a(1'b1, 2'd0, 8'h51, 1'b0);
    tick();
    chk("t5_pre", 16'(ifa.out_valid), 16'h4);
    drive_a(1'b1, 2'd0, 8'h52, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_async_valid", 16'(ifa.out_valid), 16'h0);
    chk("t5_async_busy",  16'(busy_a),        16'h0);
    tick();
    rst = 1'b0;
    drive_a(1'b1, 2'd1, 8'h60, 1'b1);
    tick();
    drive_a(1'b0, 2'd0, 8'h00, 1'b0);
    chk("t5_new_valid", 16'(ifa.out_valid), 16'h2);
    chk("t5_new_data",  16'(ifa.out_data),  16'h60);
    tick();
    chk("t5_drain", 16'(ifa.out_valid), 16'h0);

    // N=3 instance, first beat with sel=3
    drive_b(1'b1, 2'd3, 8'h77, 1'b0);
    #1;
    chk("t6_rdy0", 16'(ifb.in_ready), 16'h1);
    tick();
`ifdef DEMUX_DROP_EN
    chk("t6_drop_v0", 16'(ifb.out_valid), 16'h0);
    chk("t6_drop_p0", 16'(drop_b),        16'h0);
    drive_b(1'b1, 2'd0, 8'h78, 1'b1);
    #1;
    chk("t6_rdy1", 16'(ifb.in_ready), 16'h1);
    tick();
    drive_b(1'b0, 2'd0, 8'h00, 1'b0);
    chk("t6_drop_v1", 16'(ifb.out_valid), 16'h0);
    chk("t6_drop_p1", 16'(drop_b),        16'h1);
    tick();
    chk("t6_drop_p2", 16'(drop_b),        16'h0);
    chk("t6_busy",    16'(busy_b),        16'h0);
`else
    chk("t6_clamp_v0", 16'(ifb.out_valid), 16'h4);
    chk("t6_clamp_d0", 16'(ifb.out_data),  16'h77);
    drive_b(1'b1, 2'd0, 8'h78, 1'b1);
    #1;
    chk("t6_rdy1", 16'(ifb.in_ready), 16'h1);
    tick();
    drive_b(1'b0, 2'd0, 8'h00, 1'b0);
    chk("t6_clamp_v1", 16'(ifb.out_valid), 16'h4);
    chk("t6_clamp_d1", 16'(ifb.out_data),  16'h78);
    chk("t6_clamp_l1", 16'(ifb.out_last),  16'h1);
    tick();
    chk("t6_drain", 16'(ifb.out_valid), 16'h0);
    chk("t6_busy",  16'(busy_b),        16'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_stream_1n.md
Name: demux_stream_1n

Overview:
- 1-to-N packet demultiplexer. It is the inverse of the 2:1 mux: one input stream fans out to N output channels.
- Destination is sampled on the first beat of each packet and held until the last beat is accepted, so packets are never split across channels.
- Single registered output stage with valid/ready handshake on both sides.
- Sits between a shared producer (e.g. an arbiter or mux output) and per-channel consumers.

Parameters:
- WIDTH, 8, data width in bits
- N, 4, number of output channels (2..16)
- SELW, 2, select width; must satisfy 2**SELW >= N

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid & in_ready
- in_data  input  WIDTH  input payload
- in_last  input  1  marks final beat of packet
- sel  input  SELW  destination channel; only meaningful on the first beat of a packet
- out_valid  output  N  one-hot per-channel valid
- out_ready  input  N  per-channel ready
- out_data  output  WIDTH  payload, shared by all channels
- out_last  output  1  last flag, shared by all channels
- busy  output  1  high while a packet is in progress (state ROUTE) or the output register is occupied

Behaviour:
- Reset (asynchronous assert):
  - state = IDLE; output register empty.
  - out_valid = 0, out_data = 0, out_last = 0, busy = 0.
  - Internal cur_sel = 0, out_sel_q = 0.
  - in_ready = 1 after reset (the register is empty).
- Output register:
  - One entry holding data, last and its own destination out_sel_q.
  - out_valid[i] = occupied & (out_sel_q == i). At most one bit is set.
  - Handshake: the entry drains on out_valid[out_sel_q] & out_ready[out_sel_q].
- in_ready = ~occupied | out_ready[out_sel_q]. This is a pass-through load in the same cycle as a drain, with no bubble, so sustained throughput is 1 beat/clk.
- Latency: an accepted beat appears on the outputs on the next clock edge (1 cycle).
- FSM states:
  - IDLE, on an accepted beat:
    - Destination = sel; cur_sel <= sel.
    - If in_last = 0, go to ROUTE.
    - If in_last = 1 (single-beat packet), stay in IDLE.
  - ROUTE, on an accepted beat:
    - Destination = cur_sel; sel is ignored.
    - If in_last = 1, go to IDLE.
- out_sel_q is loaded with the beat's destination on every load. A pending beat keeps its channel even if cur_sel changes.
- Backpressure is channel-local: a stalled out_ready[j] blocks only while the register holds a beat for j. out_ready on other channels has no effect.
- in_valid without acceptance has no effect on state, and sel is not sampled.
- out_valid, out_data and out_last stay stable while stalled (valid high, ready low).
- sel out of range (sel >= N) on a first beat is handled as defined under Optional Feature.
- Reset mid-packet: the FSM returns to IDLE and any held beat is discarded. The next accepted beat is treated as a first beat.

Optional Feature:
- Macro: DEMUX_DROP_EN
- Defined:
  - A first beat with sel >= N starts a drop packet.
  - All beats of that packet are accepted with in_ready = 1 (independent of the output register) and discarded, with no out_valid.
  - Extra output port drop_pulse (1 bit) pulses high for one clk when the last beat of a dropped packet is accepted.
  - Beats still in the output register drain normally during the drop.
- Not defined:
  - sel >= N is clamped to N-1.
  - No drop_pulse port.

Test Plan:
- Reset, then one-beat packet: sel=2, data=0xA5, last=1 -> next cycle out_valid=4'b0100, out_data=0xA5, out_last=1; with out_ready=4'b1111 it drains the following cycle; busy returns to 0.
- 4-beat packet, data 0x10..0x13, sel=1 on beat 0, then sel toggled to 3 on beats 1-3 -> all four beats appear on channel 1 only, back-to-back at 1 beat/clk; out_last set only on 0x13.
- Packet to ch0 with out_ready[0]=0 for 5 cycles, out_ready[1..3]=1 -> in_ready=0 after the first beat; out_data held at 0x10 for 5 cycles; resumes without loss when out_ready[0]=1.
- Back-to-back packets, ch3 (2 beats) then ch0 (1 beat) with no idle cycle -> out_valid sequence 1000, 1000, 0001; no cycle with two valid bits set.
- Assert rst during beat 2 of a 4-beat packet to ch2 -> out_valid=0 immediately; the next packet with sel=1 routes to ch1.
- N=3, sel=3:
  - With DEMUX_DROP_EN: a 2-beat packet is accepted in 2 cycles, out_valid stays 0, and drop_pulse=1 for 1 cycle.
  - Without DEMUX_DROP_EN: the packet appears on ch2.
